// File: rtl/led_mem_resp.sv
// led_mem_resp: single-port RAM that sweeps a one-hot LED pattern into every
// word after reset, then serves read-first accesses with registered output.
// Optional build macro LED_MEM_OUTREG_EN adds a second output register
// (read latency 2 instead of 1); ready timing is the same in both builds.
module led_mem_resp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   init_addr_q;
  logic                ready_q;
  logic [DATA_W-1:0]   dout_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   led_word;
  logic                user_acc;

  assign user_acc = (state_q == S_READY) && ena;

  // One-hot LED pattern: bit (init_addr mod DATA_W) set.
  always_comb begin
    led_word = '0;
    for (int i = 0; i < DATA_W; i++)
      if ((32'(init_addr_q) % DATA_W) == i) led_word[i] = 1'b1;
  end

  // Write port mux: the init sweep owns the memory until READY; user inputs
  // are ignored before that. Writes are suppressed while reset is held so an
  // aborted access never lands.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addra;
    mem_wdata = dina;
    if (!rst) begin
      if (state_q == S_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = init_addr_q;
        mem_wdata = led_word;
      end else if (ena && wea) begin
        mem_we = 1'b1;
      end
    end
  end

  // Memory array: no reset, contents are rewritten by the sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // FSM with init counter, ready flag and first output register.
  // The read samples mem before this edge's write lands, giving read-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
      ready_q     <= 1'b0;
      dout_q      <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end
        end
        S_READY: begin
          if (user_acc) dout_q <= mem[addra];
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

`ifdef LED_MEM_OUTREG_EN
  logic [DATA_W-1:0] dout2_q;

  // Second output stage loads every cycle, so hold shows up one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout2_q <= '0;
    else     dout2_q <= dout_q;
  end

  assign douta = dout2_q;
`else
  assign douta = dout_q;
`endif

  assign ready = ready_q;

endmodule

// File: doc/led_mem_resp.md
LED_MEM_RESP -- requirements
Module: led_mem_resp

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; depth = 2^ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ena  input  1  access enable from the memory controller.
REQ-006 SHALL have port wea  input  1  write enable; qualified by ena.
REQ-007 SHALL have port addra  input  ADDR_W  word address.
REQ-008 SHALL have port dina  input  DATA_W  write data.
REQ-009 SHALL have port douta  output  DATA_W  registered read data.
REQ-010 SHALL have port ready  output  1  high once the init sweep is complete; accesses are honoured only while high.

Function
REQ-011 SHALL implement a two-state FSM: INIT and READY; reset enters INIT.
REQ-012 In INIT, an internal init_addr counter SHALL start at 0 and increment by 1 per cycle, writing mem[init_addr] = word with only bit (init_addr mod DATA_W) set (one-hot LED pattern).
REQ-013 INIT SHALL last exactly 2^ADDR_W cycles: the cycle that writes address 2^ADDR_W-1 transitions to READY, and ready SHALL rise on that edge.
REQ-014 During INIT, ena/wea/addra/dina SHALL be ignored; no user write lands, and douta SHALL stay 0.
REQ-015 In READY, ena=1, wea=0: douta SHALL equal mem[addra] one clock after the request edge (latency 1).
REQ-016 In READY, ena=1, wea=1: mem[addra] <= dina; douta SHALL load the old contents (read-first).
REQ-017 In READY, ena=0: memory unchanged; douta SHALL hold its last value.
REQ-018 Back-to-back accesses SHALL be accepted every cycle with no bubbles; a read following a write to the same address SHALL return the new data.
REQ-019 All addresses 0..2^ADDR_W-1 SHALL be valid; no out-of-range case exists.
REQ-020 READY SHALL be terminal until the next reset.

Reset
REQ-021 rst high SHALL immediately, without a clock edge, force state = INIT, init_addr = 0, ready = 0, and douta = 0 (including every pipeline register).
REQ-022 Memory contents SHALL NOT be cleared by reset itself; the INIT sweep following reset deassertion SHALL rewrite every word.
REQ-023 Reset asserted mid-INIT or mid-access SHALL abort it; after deassertion, a full 2^ADDR_W-cycle sweep SHALL restart from address 0.

Configuration
REQ-024 Macro LED_MEM_OUTREG_EN defined: a second output register SHALL follow the first and load every cycle, giving read latency 2; the hold behaviour of REQ-017 applies at the second stage one cycle later.
REQ-025 Macro LED_MEM_OUTREG_EN undefined: douta SHALL come directly from the first register, giving read latency 1; ready timing is identical in both builds.

Verification
REQ-026 Reset release, then 16 cycles with ena=1, wea=1, addra=3, dina=16'hFFFF -> ready rises after exactly 16 cycles; a subsequent read of addr 3 returns 16'h0008 (write ignored during INIT).
REQ-027 READY, read addresses 0..15 back-to-back -> douta sequence 16'h0001, 16'h0002, ... 16'h8000, each 1 cycle after its request (2 with LED_MEM_OUTREG_EN).
REQ-028 READY, write addr 5 dina=16'hA5A5 -> douta shows old value 16'h0020; a read of addr 5 next cycle returns 16'hA5A5.
REQ-029 READY, read addr 2 then ena=0 for 5 cycles -> douta holds 16'h0004 throughout.
REQ-030 rst pulsed asynchronously mid-INIT at init_addr=9, and again after writing addr 1 = 16'h1234 in READY -> douta and ready drop to 0 with no clock edge; after each reset a full 16-cycle sweep runs and addr 1 reads 16'h0002.
